vend_change_dispenser: RTL and testbench

//   Change-payout controller for the vending machine. Accepts a change amount (in

---
 rtl/vend_change_dispenser.sv | 246 ++++++++++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_dispenser.sv
// Change-payout controller: pays a nickel-unit change amount one coin at a time
// from the dime and nickel tubes, confirms each coin on the exit sensor and keeps
// a saturating inventory count for each tube.
module vend_change_dispenser #(
    parameter int CREDIT_W       = 5,
    parameter int INV_W          = 6,
    parameter int DIME_INIT      = 8,
    parameter int NICKEL_INIT    = 8,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [CREDIT_W-1:0] req_amount,
    output logic                req_ready,
    input  logic                coin_sense,
    input  logic                refill_dime,
    input  logic                refill_nickel,
    input  logic                fault_clr,
    output logic                dime_sol,
    output logic                nickel_sol,
    output logic                busy,
    output logic                fault,
    output logic                done,
    output logic [CREDIT_W-1:0] owed,
    output logic [INV_W-1:0]    dime_count,
    output logic [INV_W-1:0]    nickel_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Counter widths carry one spare bit so the +1 constants never need a zero-width pad.
    localparam int PCNT_W = $clog2(PULSE_CYCLES + 1) + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

    localparam logic [PCNT_W-1:0]   PULSE_LAST   = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [TCNT_W-1:0]   TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PCNT_W-1:0]   PCNT_ONE     = PCNT_W'(1'b1);
    localparam logic [TCNT_W-1:0]   TCNT_ONE     = TCNT_W'(1'b1);
    localparam logic [INV_W-1:0]    INV_ZERO     = {INV_W{1'b0}};
    localparam logic [INV_W-1:0]    INV_ONE      = INV_W'(1'b1);
    localparam logic [INV_W-1:0]    INV_MAX      = {INV_W{1'b1}};
    localparam logic [INV_W-1:0]    DIME_RST     = INV_W'(DIME_INIT);
    localparam logic [INV_W-1:0]    NICKEL_RST   = INV_W'(NICKEL_INIT);
    localparam logic [CREDIT_W-1:0] CREDIT_ZERO  = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] CREDIT_ONE   = CREDIT_W'(1'b1);
    localparam logic [CREDIT_W-1:0] CREDIT_TWO   = CREDIT_W'(2'd2);

    // Inventory update: jam/empty clear wins over decrement, a refill in the same
    // cycle still lands, and increment/decrement together cancel out.
    function automatic logic [INV_W-1:0] inv_next(
        input logic [INV_W-1:0] cnt,
        input logic             inc,
        input logic             dec,
        input logic             clr
    );
        logic [INV_W-1:0] res;
        if (clr) begin
            res = inc ? INV_ONE : INV_ZERO;
        end else if (inc && !dec) begin
            res = (cnt == INV_MAX) ? cnt : (cnt + INV_ONE);
        end else if (dec && !inc) begin
            res = (cnt == INV_ZERO) ? cnt : (cnt - INV_ONE);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_t              state_r,      state_nxt_s;
    logic                coin_dime_r,  coin_dime_nxt_s;
    logic                sense_lat_r,  sense_lat_nxt_s;
    logic [PCNT_W-1:0]   pulse_cnt_r,  pulse_cnt_nxt_s;
    logic [TCNT_W-1:0]   wait_cnt_r,   wait_cnt_nxt_s;
    logic [CREDIT_W-1:0] owed_r,       owed_nxt_s;
    logic [INV_W-1:0]    dime_cnt_r,   dime_cnt_nxt_s;
    logic [INV_W-1:0]    nickel_cnt_r, nickel_cnt_nxt_s;
    logic                acct_s;
    logic                jam_s;
    logic                transfer_s;

    logic req_ready_r,  req_ready_nxt_s;
    logic dime_sol_r,   dime_sol_nxt_s;
    logic nickel_sol_r, nickel_sol_nxt_s;
    logic busy_r,       busy_nxt_s;
    logic fault_r,      fault_nxt_s;
    logic done_r,       done_nxt_s;

    assign transfer_s = req_valid & req_ready_r;

    // State and datapath registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            coin_dime_r  <= 1'b0;
            sense_lat_r  <= 1'b0;
            pulse_cnt_r  <= {PCNT_W{1'b0}};
            wait_cnt_r   <= {TCNT_W{1'b0}};
            owed_r       <= CREDIT_ZERO;
            dime_cnt_r   <= DIME_RST;
            nickel_cnt_r <= NICKEL_RST;
        end else begin
            state_r      <= state_nxt_s;
            coin_dime_r  <= coin_dime_nxt_s;
            sense_lat_r  <= sense_lat_nxt_s;
            pulse_cnt_r  <= pulse_cnt_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
            owed_r       <= owed_nxt_s;
            dime_cnt_r   <= dime_cnt_nxt_s;
            nickel_cnt_r <= nickel_cnt_nxt_s;
        end
    end

    // Next-state logic: coin selection, pulse/timeout sequencing and coin accounting.
    always_comb begin
        state_nxt_s     = state_r;
        coin_dime_nxt_s = coin_dime_r;
        sense_lat_nxt_s = sense_lat_r;
        pulse_cnt_nxt_s = pulse_cnt_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        owed_nxt_s      = owed_r;
        acct_s          = 1'b0;
        jam_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    owed_nxt_s  = req_amount;
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                sense_lat_nxt_s = 1'b0;
                pulse_cnt_nxt_s = {PCNT_W{1'b0}};
                if (owed_r == CREDIT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else if ((owed_r >= CREDIT_TWO) && (dime_cnt_r != INV_ZERO)) begin
                    coin_dime_nxt_s = 1'b1;
                    state_nxt_s     = ST_DRIVE;
                end else if (nickel_cnt_r != INV_ZERO) begin
                    // Nickels also cover the case where dimes have run out.
                    coin_dime_nxt_s = 1'b0;
                    state_nxt_s     = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            ST_DRIVE: begin
                // A coin seen mid-pulse is remembered; the pulse always runs to length.
                sense_lat_nxt_s = sense_lat_r | coin_sense;
                if (pulse_cnt_r == PULSE_LAST) begin
                    if (sense_lat_r || coin_sense) begin
                        acct_s      = 1'b1;
                        state_nxt_s = ST_SELECT;
                    end else begin
                        wait_cnt_nxt_s = {TCNT_W{1'b0}};
                        state_nxt_s    = ST_WAIT;
                    end
                end else begin
                    pulse_cnt_nxt_s = pulse_cnt_r + PCNT_ONE;
                end
            end
            ST_WAIT: begin
                if (coin_sense) begin
                    acct_s      = 1'b1;
                    state_nxt_s = ST_SELECT;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    // No coin arrived: treat the tube as jammed or empty.
                    jam_s       = 1'b1;
                    state_nxt_s = ST_FAULT;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + TCNT_ONE;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (acct_s) begin
            owed_nxt_s = owed_r - (coin_dime_r ? CREDIT_TWO : CREDIT_ONE);
        end else begin
            owed_nxt_s = owed_nxt_s;
        end

        dime_cnt_nxt_s   = inv_next(dime_cnt_r, refill_dime,
                                    acct_s & coin_dime_r, jam_s & coin_dime_r);
        nickel_cnt_nxt_s = inv_next(nickel_cnt_r, refill_nickel,
                                    acct_s & ~coin_dime_r, jam_s & ~coin_dime_r);
    end

    // Output decode from the upcoming state so every output is a plain flop.
    always_comb begin
        req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        fault_nxt_s      = (state_nxt_s == ST_FAULT);
        dime_sol_nxt_s   = (state_nxt_s == ST_DRIVE) &&  coin_dime_nxt_s;
        nickel_sol_nxt_s = (state_nxt_s == ST_DRIVE) && !coin_dime_nxt_s;
        done_nxt_s       = (state_r == ST_SELECT) && (state_nxt_s == ST_IDLE);
    end

    // Output registers; reset leaves the block ready and all drives off.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
            dime_sol_r   <= 1'b0;
            nickel_sol_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            req_ready_r  <= req_ready_nxt_s;
            busy_r       <= busy_nxt_s;
            fault_r      <= fault_nxt_s;
            dime_sol_r   <= dime_sol_nxt_s;
            nickel_sol_r <= nickel_sol_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign req_ready    = req_ready_r;
    assign busy         = busy_r;
    assign fault        = fault_r;
    assign dime_sol     = dime_sol_r;
    assign nickel_sol   = nickel_sol_r;
    assign done         = done_r;
    assign owed         = owed_r;
    assign dime_count   = dime_cnt_r;
    assign nickel_count = nickel_cnt_r;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed self-checking bench for vend_change_dispenser with default parameters.
module tb_vend_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [4:0] req_amount;
    logic       req_ready;
    logic       coin_sense;
    logic       refill_dime;
    logic       refill_nickel;
    logic       fault_clr;
    logic       dime_sol;
    logic       nickel_sol;
    logic       busy;
    logic       fault;
    logic       done;
    logic [4:0] owed;
    logic [5:0] dime_count;
    logic [5:0] nickel_count;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int sol_cyc  = 0;

    vend_change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .coin_sense   (coin_sense),
        .refill_dime  (refill_dime),
        .refill_nickel(refill_nickel),
        .fault_clr    (fault_clr),
        .dime_sol     (dime_sol),
        .nickel_sol   (nickel_sol),
        .busy         (busy),
        .fault        (fault),
        .done         (done),
        .owed         (owed),
        .dime_count   (dime_count),
        .nickel_count (nickel_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Activity monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dime_sol && nickel_sol) both_cnt++;
        if (dime_sol || nickel_sol) sol_cyc++;
    end

    // Hang guard.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [4:0] amt);
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid  = 1'b0;
        req_amount = 5'd0;
    endtask

    // Wait for the chosen solenoid, measure its pulse, then sense the coin
    // two cycles after the pulse ends (optionally with a coincident dime refill).
    task automatic pay_coin(input bit is_dime, input bit refill_with_sense);
        int guard;
        int w;
        guard = 0;
        while (!(is_dime ? dime_sol : nickel_sol) && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("sol_start", (guard < 20), 1);
        w = 0;
        while ((is_dime ? dime_sol : nickel_sol) && w < 20) begin
            check("sol_exclusive", (is_dime ? nickel_sol : dime_sol), 0);
            w++;
            @(negedge clk);
        end
        check("pulse_width", w, 4);
        @(negedge clk);
        coin_sense  = 1'b1;
        refill_dime = refill_with_sense;
        @(negedge clk);
        coin_sense  = 1'b0;
        refill_dime = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!done && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("done_seen", (guard < 20), 1);
        @(negedge clk);
    endtask

    initial begin
        int snap;
        int c;
        reset = 1'b1; req_valid = 1'b0; req_amount = 5'd0; coin_sense = 1'b0;
        refill_dime = 1'b0; refill_nickel = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_done", done, 0);
        check("rst_owed", owed, 0);
        check("rst_dime_cnt", dime_count, 8);
        check("rst_nickel_cnt", nickel_count, 8);
        check("rst_sols", {dime_sol, nickel_sol}, 0);

        // 1: pay 3 -> one dime, one nickel
        snap = done_cnt;
        drive_req(5'd3);
        check("t1_req_ready_low", req_ready, 0);
        check("t1_busy", busy, 1);
        pay_coin(1'b1, 1'b0);
        check("t1_owed_mid", owed, 1);
        pay_coin(1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        check("t1_done_once", done_cnt - snap, 1);
        check("t1_owed", owed, 0);
        check("t1_dime_cnt", dime_count, 7);
        check("t1_nickel_cnt", nickel_count, 7);
        check("t1_req_ready", req_ready, 1);

        // 2: pay 0 -> done two cycles after accept, no coins
        snap = sol_cyc;
        drive_req(5'd0);
        check("t2_done_early", done, 0);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_req_ready", req_ready, 1);
        check("t2_busy", busy, 0);
        @(negedge clk);
        check("t2_done_width", done, 0);
        check("t2_no_sol", sol_cyc - snap, 0);

        // 3: pay 2 with no sensor -> timeout fault, then refill and retry
        drive_req(5'd2);
        c = 0;
        while (!dime_sol && c < 20) begin c++; @(negedge clk); end
        c = 0;
        while (dime_sol && c < 20) begin c++; @(negedge clk); end
        check("t3_pulse_width", c, 4);
        c = 0;
        while (!fault && c < 200) begin c++; @(negedge clk); end
        check("t3_timeout_cycles", c, 64);
        check("t3_fault", fault, 1);
        check("t3_owed", owed, 2);
        check("t3_dime_cnt", dime_count, 0);
        check("t3_busy", busy, 1);
        check("t3_req_ready", req_ready, 0);
        refill_dime = 1'b1;
        @(negedge clk);
        refill_dime = 1'b0;
        check("t3_refill", dime_count, 1);
        check("t3_fault_holds", fault, 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("t3_fault_cleared", fault, 0);
        pay_coin(1'b1, 1'b0);
        wait_done();
        check("t3_owed_end", owed, 0);
        check("t3_dime_end", dime_count, 0);
        check("t3_nickel_end", nickel_count, 7);

        // 4: drain 7 nickels, then pay 1 with both tubes empty
        drive_req(5'd7);
        for (int i = 0; i < 7; i++) pay_coin(1'b0, 1'b0);
        wait_done();
        check("t4_nickel_cnt", nickel_count, 0);
        snap = sol_cyc;
        drive_req(5'd1);
        check("t4_select_no_fault", fault, 0);
        @(negedge clk);
        check("t4_fault", fault, 1);
        check("t4_sols", {dime_sol, nickel_sol}, 0);
        check("t4_owed", owed, 1);
        coin_sense = 1'b1;
        @(negedge clk);
        coin_sense = 1'b0;
        @(negedge clk);
        check("t4_sense_ignored_owed", owed, 1);
        check("t4_sense_ignored_cnt", nickel_count, 0);
        check("t4_no_sol", sol_cyc - snap, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_reset_fault", fault, 0);
        check("t4_reset_dime", dime_count, 8);

        // 5: refill coincident with dime accounting, then saturation
        drive_req(5'd2);
        pay_coin(1'b1, 1'b1);
        check("t5_refill_cancel", dime_count, 8);
        check("t5_owed", owed, 0);
        wait_done();
        for (int i = 0; i < 70; i++) begin
            refill_dime = 1'b1;
            @(negedge clk);
        end
        refill_dime = 1'b0;
        @(negedge clk);
        check("t5_saturate", dime_count, 63);

        // 6: reset in the middle of a dime pulse
        drive_req(5'd2);
        c = 0;
        while (!dime_sol && c < 20) begin c++; @(negedge clk); end
        check("t6_sol_on", dime_sol, 1);
        @(negedge clk);
        snap = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_sol_off", dime_sol, 0);
        check("t6_owed", owed, 0);
        check("t6_dime_cnt", dime_count, 8);
        check("t6_nickel_cnt", nickel_count, 8);
        check("t6_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt - snap, 0);
        check("t6_req_ready", req_ready, 1);

        // 7: refill landing on the timeout cycle leaves one dime
        drive_req(5'd2);
        c = 0;
        while (!dime_sol && c < 20) begin c++; @(negedge clk); end
        c = 0;
        while (dime_sol && c < 20) begin c++; @(negedge clk); end
        c = 0;
        while (!fault && c < 200) begin
            refill_dime = (c == 63);
            c++;
            @(negedge clk);
        end
        refill_dime = 1'b0;
        check("t7_timeout_cycles", c, 64);
        check("t7_dime_cnt", dime_count, 1);
        check("t7_owed", owed, 2);

        check("never_both_sols", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
